// File: rtl/alu_scheduler_pkg.sv
// definitions: shared opcode, instruction and FSM state types for the ALU scheduler.
package definitions;
  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, RSVD = 2'd3} opcode_t;
  typedef struct packed {
    opcode_t     opcode;
    logic [15:0] a;
    logic [15:0] b;
  } instruction_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;
  function automatic logic [31:0] multiplier(input logic [15:0] a, input logic [15:0] b);
    return {16'd0, a} * {16'd0, b};
  endfunction
endpackage

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: requester and response handshake bundle around the shared ALU.
interface alu_scheduler_if import definitions::*; #(parameter int NUM_REQ = 4);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  instruction_t [NUM_REQ-1:0]       req_instr;
  logic                             resp_valid;
  logic                             resp_ready;
  logic [ID_W-1:0]                  resp_id;
  logic [31:0]                      resp_result;
  logic                             resp_error;
  modport master (output req_valid, req_instr, resp_ready,
                  input  req_ready, resp_valid, resp_id, resp_result, resp_error);
  modport slave  (input  req_valid, req_instr, resp_ready,
                  output req_ready, resp_valid, resp_id, resp_result, resp_error);
endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);
  logic [IDX_W-1:0] k;
  // scan farthest-first so the candidate nearest ptr wins
  always_comb begin
    idx = '0;
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (req[k]) idx = k;
    end
  end
  assign grant = (|req) ? (NUM_REQ'(1) << idx) : '0;
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sharing of one ADD/SUB/MUL unit between NUM_REQ requesters.
module alu_scheduler import definitions::*; #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  alu_scheduler_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  sched_state_t state, next;
  logic [ID_W-1:0] rr_ptr, gidx;
  logic [NUM_REQ-1:0] grant;
  instruction_t instr_q;
  logic [CW-1:0] cnt;
  logic [31:0] wa, wb, alu;
  logic hs;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx)
  );
  assign hs = (state == IDLE) && (|bus.req_valid);
  assign bus.resp_valid = (state == RESP);
  assign busy = (state != IDLE);
  assign wa = {16'd0, instr_q.a};
  assign wb = {16'd0, instr_q.b};
  always_comb begin
    bus.req_ready = (state == IDLE) ? grant : '0;
    next = hs ? EXEC
         : (state == EXEC && cnt == '0) ? RESP
         : (state == RESP && bus.resp_ready) ? IDLE
         : state;
  end
  always_comb begin
    alu = (instr_q.opcode == ADD) ? wa + wb
        : (instr_q.opcode == SUB) ? wa - wb
        : (instr_q.opcode == MUL) ? multiplier(instr_q.a, instr_q.b)
        : 32'd0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      instr_q         <= '0;
      cnt             <= '0;
      bus.resp_id     <= '0;
      bus.resp_result <= '0;
      bus.resp_error  <= 1'b0;
      op_count        <= '0;
    end else begin
      state <= next;
      if (hs) begin
        instr_q     <= bus.req_instr[gidx];
        bus.resp_id <= gidx;
        rr_ptr      <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        cnt         <= (bus.req_instr[gidx].opcode == MUL) ? CW'(MUL_LATENCY - 1) : '0;
      end
      if (state == EXEC && cnt != '0) cnt <= cnt - 1'b1;
      if (state == EXEC && cnt == '0) begin
        bus.resp_result <= alu;
        bus.resp_error  <= (instr_q.opcode == RSVD);
      end
      if (state == RESP && bus.resp_ready) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed vector table plus arbitration, back-pressure, reset and wrap sequences.
module tb_alu_scheduler;
  import definitions::*;
  typedef struct {
    int           r;
    instruction_t ins;
    logic [31:0]  res;
    logic         err;
    int           lat;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic [3:0] op_count;
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  vec_t v [8];
  alu_scheduler_if #(.NUM_REQ(4)) bus ();
  alu_scheduler #(.NUM_REQ(4), .MUL_LATENCY(3), .CNT_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .busy     (busy),
    .op_count (op_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // called at posedge+1; returns cycles from handshake cycle c to first resp_valid
  task automatic do_op(input int r, input instruction_t ins, output int lat);
    int n = 0;
    bus.req_valid[r] = 1'b1;
    bus.req_instr[r] = ins;
    #1;
    while (!bus.req_ready[r] && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("grant_wait", 32'(n < 20), 32'd1);
    @(posedge clock); #1;
    bus.req_valid[r] = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask
  initial begin
    int lat;
    int k;
    v[0] = '{0, '{opcode: ADD,  a: 16'd5,      b: 16'd7},      32'd12,          1'b0, 2};
    v[1] = '{2, '{opcode: SUB,  a: 16'd3,      b: 16'd10},     32'hFFFF_FFF9,   1'b0, 2};
    v[2] = '{1, '{opcode: MUL,  a: 16'hFFFF,   b: 16'hFFFF},   32'hFFFE_0001,   1'b0, 4};
    v[3] = '{3, '{opcode: RSVD, a: 16'd9,      b: 16'd9},      32'd0,           1'b1, 2};
    v[4] = '{1, '{opcode: ADD,  a: 16'hFFFF,   b: 16'hFFFF},   32'h0001_FFFE,   1'b0, 2};
    v[5] = '{0, '{opcode: SUB,  a: 16'd10,     b: 16'd3},      32'd7,           1'b0, 2};
    v[6] = '{2, '{opcode: MUL,  a: 16'd300,    b: 16'd200},    32'd60000,       1'b0, 4};
    v[7] = '{3, '{opcode: SUB,  a: 16'd0,      b: 16'd1},      32'hFFFF_FFFF,   1'b0, 2};
    bus.req_valid = '0;
    bus.req_instr = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_resp_result", bus.resp_result, 32'd0);
    check("rst_resp_error", 32'(bus.resp_error), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].r, v[i].ins, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
      check($sformatf("v%0d_id", i), 32'(bus.resp_id), 32'(v[i].r));
      check($sformatf("v%0d_result", i), bus.resp_result, v[i].res);
      check($sformatf("v%0d_error", i), 32'(bus.resp_error), 32'(v[i].err));
      @(posedge clock); #1;
      exp_cnt = (exp_cnt + 1) % 16;
      check($sformatf("v%0d_op_count", i), 32'(op_count), 32'(exp_cnt));
      check($sformatf("v%0d_valid_drop", i), 32'(bus.resp_valid), 32'd0);
    end
    // all four requesters contend; pointer sits at 0 after the last grant to 3
    for (int i = 0; i < 4; i++) bus.req_instr[i] = '{opcode: ADD, a: 16'(i), b: 16'd100};
    bus.req_valid = 4'b1111;
    k = 0;
    for (int c = 0; c < 100 && k < 8; c++) begin
      @(negedge clock);
      check("rr_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
      if (bus.resp_valid) begin
        check($sformatf("rr%0d_id", k), 32'(bus.resp_id), 32'(k % 4));
        check($sformatf("rr%0d_result", k), bus.resp_result, 32'(100 + k % 4));
        k++;
        if (k == 8) bus.req_valid = '0;
      end
    end
    check("rr_count", 32'(k), 32'd8);
    @(posedge clock); #1;
    exp_cnt = (exp_cnt + 8) % 16;
    check("wrap_op_count", 32'(op_count), 32'(exp_cnt));
    // back-pressure with a competing requester waiting
    bus.resp_ready = 1'b0;
    do_op(1, '{opcode: ADD, a: 16'd40, b: 16'd2}, lat);
    check("bp_latency", 32'(lat), 32'd2);
    bus.req_instr[2] = '{opcode: ADD, a: 16'd1, b: 16'd1};
    bus.req_valid[2] = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), 32'(bus.resp_valid), 32'd1);
      check($sformatf("bp%0d_id", i), 32'(bus.resp_id), 32'd1);
      check($sformatf("bp%0d_result", i), bus.resp_result, 32'd42);
      check($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp%0d_op_count", i), 32'(op_count), 32'(exp_cnt));
      @(posedge clock); #1;
    end
    bus.resp_ready = 1'b1;
    bus.req_valid[2] = 1'b0;
    @(posedge clock); #1;
    exp_cnt = (exp_cnt + 1) % 16;
    check("bp_op_count", 32'(op_count), 32'(exp_cnt));
    check("bp_valid_drop", 32'(bus.resp_valid), 32'd0);
    // reset during MUL EXEC; pointer would otherwise favour requester 2
    bus.req_instr[1] = '{opcode: MUL, a: 16'd3, b: 16'd4};
    bus.req_valid[1] = 1'b1;
    #1;
    check("mr_grant", 32'(bus.req_ready), 32'b0010);
    @(posedge clock); #1;
    bus.req_valid[1] = 1'b0;
    check("mr_busy_exec", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mr_op_count", 32'(op_count), 32'd0);
    bus.req_valid = 4'b0101;
    #1;
    check("mr_rr_ptr", 32'(bus.req_ready), 32'b0001);
    reset = 1'b0;
    bus.req_valid = '0;
    @(posedge clock); #1;
    check("mr_idle", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
